abl_gen: RTL and testbench

ABL_GEN -- requirements
Module: abl_gen

---
 rtl/abl_gen.sv | 268 ++++++++++++++++++++++++++
 tb/tb_abl_gen.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abl_gen.sv
//-----------------------------------------------------------------------------
// abl_gen -- low-byte address generator.
//
// Builds the low half of an address from a selectable base (0, PCL, the head
// of a small address-hold FIFO, or the data bus) plus an offset (REG, ABL
// and/or carry-in). The adder result ADL/CO is combinational. ABL registers
// ADL every enabled cycle. PCL loads ABL+inc_pc on request. An optional
// page-fixup FSM flags indexed accesses that crossed a page boundary.
//
// Parameters:
//   WIDTH       width of every address/data path (8..16)
//   HOLD_DEPTH  entries in the address-hold FIFO (1..4)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   rdy        global enable; all state holds while low
//   CI         adder carry-in
//   cond       condition code; picks DB as base when op[3:2]=11
//   DB         data bus
//   REG        register-file output
//   op         [3:2] base select, [1:0] offset select
//   ld_ahl     push DB into the hold FIFO
//   rd_ahl     pop the hold FIFO head at the end of the cycle
//   ld_pc      load PCL with ABL+inc_pc
//   inc_pc     increment added when loading PCL
//   CO, ADL    adder carry and result (combinational)
//   ABL        registered address
//   PCL        program counter low
//   pcl_co     carry out of ABL+inc_pc
//   ahl_empty  hold FIFO empty
//   ahl_full   hold FIFO full
//   fix_req    page-fixup request (FSM in FIX state)
//
// Build option:
//   ABL_GEN_FIXUP_EN  when defined, the page-fixup FSM is built; otherwise
//                     fix_req is tied low.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module abl_gen #(
   parameter int WIDTH      = 8,
   parameter int HOLD_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy,
   input  logic             CI,
   input  logic             cond,
   input  logic [WIDTH-1:0] DB,
   input  logic [WIDTH-1:0] REG,
   input  logic [3:0]       op,
   input  logic             ld_ahl,
   input  logic             rd_ahl,
   input  logic             ld_pc,
   input  logic             inc_pc,
   output logic             CO,
   output logic [WIDTH-1:0] ADL,
   output logic [WIDTH-1:0] ABL,
   output logic [WIDTH-1:0] PCL,
   output logic             pcl_co,
   output logic             ahl_empty,
   output logic             ahl_full,
   output logic             fix_req
);

   // A depth-1 FIFO still needs a 1-bit pointer so the vectors stay legal.
   localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
   localparam int CNT_W = $clog2(HOLD_DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(HOLD_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HOLD_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

   // Circular pointer advance; wraps explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_LAST) begin
         r = PTR_ZERO;
      end else begin
         r = p + PTR_W'(1'b1);
      end
      return r;
   endfunction

   // Zero-extend a data word to adder width.
   function automatic logic [WIDTH:0] zext(input logic [WIDTH-1:0] v);
      return {1'b0, v};
   endfunction

   // Zero-extend a single bit to adder width.
   function automatic logic [WIDTH:0] bext(input logic b);
      return {{WIDTH{1'b0}}, b};
   endfunction

   // State registers and next-state values
   logic [WIDTH-1:0] abl_q, abl_d;
   logic [WIDTH-1:0] pcl_q, pcl_d;
   logic [WIDTH-1:0] mem_q [HOLD_DEPTH];
   logic [WIDTH-1:0] mem_d [HOLD_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Combinational signals
   logic             push_s;
   logic             pop_s;
   logic [WIDTH-1:0] ahl_s;
   logic [WIDTH-1:0] base_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   pc_sum_s;

   // Hold FIFO next state. A pop is only honoured when non-empty; a push is
   // honoured when not full or when a simultaneous pop frees the slot. When
   // full, wr_ptr equals rd_ptr, so push+pop overwrites the slot being freed.
   always_comb begin
      pop_s    = rdy & rd_ahl & (cnt_q != CNT_ZERO);
      push_s   = rdy & ld_ahl & ((cnt_q != CNT_FULL) | pop_s);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = DB;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Head of the FIFO; stale storage is masked to zero once emptied.
   always_comb begin
      ahl_s = DATA_ZERO;
      if (cnt_q == CNT_ZERO) begin
         ahl_s = DATA_ZERO;
      end else begin
         ahl_s = mem_q[rd_ptr_q];
      end
   end

   // Base selection; DB is only used as base when cond qualifies op[3:2]=11.
   always_comb begin
      base_s = DATA_ZERO;
      casez ({cond, op[3:2]})
         3'b?00:  base_s = DATA_ZERO;
         3'b?01:  base_s = pcl_q;
         3'b?10:  base_s = ahl_s;
         3'b011:  base_s = DATA_ZERO;
         3'b111:  base_s = DB;
         default: base_s = DATA_ZERO;
      endcase
   end

   // Offset adder; WIDTH+1 bits so the carry is kept for CO.
   always_comb begin
      sum_s = {(WIDTH+1){1'b0}};
      case (op[1:0])
         2'b00:   sum_s = zext(REG) + bext(CI);
         2'b01:   sum_s = zext(base_s) + zext(REG) + bext(CI);
         2'b10:   sum_s = zext(base_s) + bext(CI);
         2'b11:   sum_s = zext(base_s) + zext(abl_q) + bext(CI);
         default: sum_s = {(WIDTH+1){1'b0}};
      endcase
   end

   // PC increment path and ABL/PCL next-state selection.
   always_comb begin
      pc_sum_s = zext(abl_q) + bext(inc_pc);
      abl_d    = abl_q;
      pcl_d    = pcl_q;
      if (rdy) begin
         abl_d = sum_s[WIDTH-1:0];
      end else begin
         abl_d = abl_q;
      end
      if (rdy && ld_pc) begin
         pcl_d = pc_sum_s[WIDTH-1:0];
      end else begin
         pcl_d = pcl_q;
      end
   end

   // Datapath and FIFO registers with synchronous reset that also clears storage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         abl_q    <= DATA_ZERO;
         pcl_q    <= DATA_ZERO;
         rd_ptr_q <= PTR_ZERO;
         wr_ptr_q <= PTR_ZERO;
         cnt_q    <= CNT_ZERO;
         for (int i = 0; i < HOLD_DEPTH; i++) begin
            mem_q[i] <= DATA_ZERO;
         end
      end else begin
         abl_q    <= abl_d;
         pcl_q    <= pcl_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   assign CO        = sum_s[WIDTH];
   assign ADL       = sum_s[WIDTH-1:0];
   assign ABL       = abl_q;
   assign PCL       = pcl_q;
   assign pcl_co    = pc_sum_s[WIDTH];
   assign ahl_empty = (cnt_q == CNT_ZERO);
   assign ahl_full  = (cnt_q == CNT_FULL);

`ifdef ABL_GEN_FIXUP_EN
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FIX  = 1'b1
   } fix_state_e;

   fix_state_e state_q, state_d;

   // Page-fixup next state: an indexed AHL+REG access that carried out
   // requests one fixup cycle; FIX waits for an enabled cycle to retire.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rdy && (op == 4'b1001) && sum_s[WIDTH]) begin
               state_d = FIX;
            end else begin
               state_d = IDLE;
            end
         end
         FIX: begin
            if (rdy) begin
               state_d = IDLE;
            end else begin
               state_d = FIX;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Page-fixup state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign fix_req = (state_q == FIX);
`else
   assign fix_req = 1'b0;
`endif

endmodule

// File: tb/tb_abl_gen.sv
`timescale 1ns/1ps
module tb_abl_gen;

   typedef struct {
      logic       cond;
      logic [3:0] op;
      logic       ci;
      logic [7:0] db;
      logic [7:0] rg;
      logic [7:0] e_adl;
      logic       e_co;
   } vec_t;

   logic clk;
   logic rst_n;

   // narrow instance (WIDTH=8, HOLD_DEPTH=2)
   logic rdy, ci, cond, ld_ahl, rd_ahl, ld_pc, inc_pc;
   logic [7:0] db, rg;
   logic [3:0] op;
   logic co, pcl_co, empty, full, fix;
   logic [7:0] adl, abl, pcl;

   // wide instance (WIDTH=16, HOLD_DEPTH=1)
   logic w_rdy, w_ci, w_cond, w_ld_ahl, w_rd_ahl, w_ld_pc, w_inc_pc;
   logic [15:0] w_db, w_rg;
   logic [3:0] w_op;
   logic w_co, w_pcl_co, w_empty, w_full, w_fix;
   logic [15:0] w_adl, w_abl, w_pcl;

   int n_tests;
   int n_fail;
   bit chk_model;
   bit fix_en;

   // reference model state (narrow instance)
   logic [7:0] m_abl;
   logic [7:0] m_pcl;
   logic [7:0] m_q[$];
   logic       m_fix;

   vec_t tbl[13];

   abl_gen #(.WIDTH(8), .HOLD_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .CI(ci), .cond(cond), .DB(db),
      .REG(rg), .op(op), .ld_ahl(ld_ahl), .rd_ahl(rd_ahl), .ld_pc(ld_pc),
      .inc_pc(inc_pc), .CO(co), .ADL(adl), .ABL(abl), .PCL(pcl),
      .pcl_co(pcl_co), .ahl_empty(empty), .ahl_full(full), .fix_req(fix)
   );

   abl_gen #(.WIDTH(16), .HOLD_DEPTH(1)) dut_w (
      .clk(clk), .rst_n(rst_n), .rdy(w_rdy), .CI(w_ci), .cond(w_cond), .DB(w_db),
      .REG(w_rg), .op(w_op), .ld_ahl(w_ld_ahl), .rd_ahl(w_rd_ahl), .ld_pc(w_ld_pc),
      .inc_pc(w_inc_pc), .CO(w_co), .ADL(w_adl), .ABL(w_abl), .PCL(w_pcl),
      .pcl_co(w_pcl_co), .ahl_empty(w_empty), .ahl_full(w_full), .fix_req(w_fix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected adder result from the specification's base/offset rules.
   function automatic int model_sum();
      int base;
      int head;
      int s;
      head = (m_q.size() > 0) ? int'(m_q[0]) : 0;
      if (op[3:2] == 2'd0)      base = 0;
      else if (op[3:2] == 2'd1) base = int'(m_pcl);
      else if (op[3:2] == 2'd2) base = head;
      else                      base = cond ? int'(db) : 0;
      if (op[1:0] == 2'd0)      s = int'(rg) + int'(ci);
      else if (op[1:0] == 2'd1) s = base + int'(rg) + int'(ci);
      else if (op[1:0] == 2'd2) s = base + int'(ci);
      else                      s = base + int'(m_abl) + int'(ci);
      return s;
   endfunction

   task automatic model_edge();
      int s;
      int pc;
      s  = model_sum();
      pc = int'(m_abl) + int'(inc_pc);
      if (!rst_n) begin
         m_abl = 8'h00;
         m_pcl = 8'h00;
         m_q.delete();
         m_fix = 1'b0;
      end else if (rdy) begin
         if (fix_en) begin
            if (m_fix)                          m_fix = 1'b0;
            else if (op == 4'b1001 && s > 255)  m_fix = 1'b1;
         end
         if (ld_pc) m_pcl = 8'(pc % 256);
         m_abl = 8'(s % 256);
         if (rd_ahl && m_q.size() > 0) void'(m_q.pop_front());
         if (ld_ahl && m_q.size() < 2) m_q.push_back(db);
      end
   endtask

   task automatic model_check();
      int s;
      int pc;
      s  = model_sum();
      pc = int'(m_abl) + int'(inc_pc);
      chk("rnd_adl",   32'(adl),    32'(s % 256));
      chk("rnd_co",    32'(co),     32'(s > 255));
      chk("rnd_abl",   32'(abl),    32'(m_abl));
      chk("rnd_pcl",   32'(pcl),    32'(m_pcl));
      chk("rnd_pclco", 32'(pcl_co), 32'(pc > 255));
      chk("rnd_empty", 32'(empty),  32'(m_q.size() == 0));
      chk("rnd_full",  32'(full),   32'(m_q.size() == 2));
      chk("rnd_fix",   32'(fix),    32'(m_fix));
   endtask

   // One clock: check/model before the edge, then settle 1 time unit after it.
   task automatic tick();
      @(negedge clk);
      if (chk_model) model_check();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy = 1'b0; ci = 1'b0; cond = 1'b0; ld_ahl = 1'b0; rd_ahl = 1'b0;
      ld_pc = 1'b0; inc_pc = 1'b0; db = 8'h00; rg = 8'h00; op = 4'b0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      chk_model = 1'b0;
`ifdef ABL_GEN_FIXUP_EN
      fix_en = 1'b1;
`else
      fix_en = 1'b0;
`endif
      m_abl = 8'h00; m_pcl = 8'h00; m_fix = 1'b0;
      idle();
      w_rdy = 1'b0; w_ci = 1'b0; w_cond = 1'b0; w_ld_ahl = 1'b0; w_rd_ahl = 1'b0;
      w_ld_pc = 1'b0; w_inc_pc = 1'b0; w_db = 16'h0000; w_rg = 16'h0000; w_op = 4'b0000;

      // state for the table: ABL=30, PCL=2F, head=40
      tbl[0]  = '{1'b0, 4'b0000, 1'b0, 8'h00, 8'h11, 8'h11, 1'b0};
      tbl[1]  = '{1'b0, 4'b0001, 1'b1, 8'h00, 8'h11, 8'h12, 1'b0};
      tbl[2]  = '{1'b0, 4'b0101, 1'b0, 8'h00, 8'h10, 8'h3F, 1'b0};
      tbl[3]  = '{1'b0, 4'b0110, 1'b1, 8'h00, 8'h00, 8'h30, 1'b0};
      tbl[4]  = '{1'b0, 4'b0111, 1'b0, 8'h00, 8'h00, 8'h5F, 1'b0};
      tbl[5]  = '{1'b0, 4'b1010, 1'b0, 8'h00, 8'h00, 8'h40, 1'b0};
      tbl[6]  = '{1'b0, 4'b1011, 1'b1, 8'h00, 8'h00, 8'h71, 1'b0};
      tbl[7]  = '{1'b0, 4'b1101, 1'b0, 8'h99, 8'h10, 8'h10, 1'b0};
      tbl[8]  = '{1'b1, 4'b1101, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b1};
      tbl[9]  = '{1'b1, 4'b0110, 1'b0, 8'h00, 8'h00, 8'h2F, 1'b0};
      tbl[10] = '{1'b0, 4'b0001, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[11] = '{1'b1, 4'b1111, 1'b1, 8'hFF, 8'h00, 8'h30, 1'b1};
      tbl[12] = '{1'b1, 4'b1001, 1'b0, 8'h01, 8'hFF, 8'h3F, 1'b1};

      // reset state and first cycle after reset
      rst_n = 1'b0;
      tick();
      rdy = 1'b1; ld_ahl = 1'b1; ld_pc = 1'b1; db = 8'h77;
      tick();
      rst_n = 1'b1;
      idle();
      chk("rst_abl",   32'(abl),   32'h0);
      chk("rst_pcl",   32'(pcl),   32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full",  32'(full),  32'h0);
      chk("rst_fix",   32'(fix),   32'h0);
      rg = 8'h5A; ci = 1'b1; #1;
      chk("post_rst_reg", 32'(adl), 32'h5B);
      op = 4'b1011; ci = 1'b0; #1;
      chk("post_rst_ahl_abl", 32'(adl), 32'h00);

      // build state for the vector table
      rdy = 1'b1; op = 4'b0000; rg = 8'h2F; ci = 1'b0;
      tick();
      rg = 8'h30; ld_pc = 1'b1; ld_ahl = 1'b1; db = 8'h40;
      tick();
      idle();
      for (int i = 0; i < 13; i++) begin
         cond = tbl[i].cond; op = tbl[i].op; ci = tbl[i].ci;
         db = tbl[i].db; rg = tbl[i].rg;
         #1;
         chk($sformatf("vec%0d_adl", i), 32'(adl), 32'(tbl[i].e_adl));
         chk($sformatf("vec%0d_co", i),  32'(co),  32'(tbl[i].e_co));
      end
      idle();

      // queue order
      do_reset();
      rdy = 1'b1; ld_ahl = 1'b1; db = 8'h34; tick();
      db = 8'h12; tick();
      ld_ahl = 1'b0; op = 4'b1010; #1;
      chk("q_head0", 32'(adl), 32'h34);
      rd_ahl = 1'b1; tick();
      chk("q_head1", 32'(adl), 32'h12);
      tick();
      rd_ahl = 1'b0; #1;
      chk("q_empty", 32'(empty), 32'h1);
      chk("q_head_empty", 32'(adl), 32'h00);

      // overflow / underflow
      idle(); do_reset();
      rdy = 1'b1; ld_ahl = 1'b1; db = 8'hAA; tick();
      db = 8'hBB; tick();
      db = 8'hCC; tick();
      ld_ahl = 1'b0; op = 4'b1010; #1;
      chk("ovf_full", 32'(full), 32'h1);
      chk("ovf_head", 32'(adl),  32'hAA);
      rd_ahl = 1'b1; tick();
      chk("ovf_head2", 32'(adl), 32'hBB);
      chk("ovf_notfull", 32'(full), 32'h0);
      tick();
      chk("unf_empty1", 32'(empty), 32'h1);
      tick();
      rd_ahl = 1'b0; #1;
      chk("unf_empty2", 32'(empty), 32'h1);
      chk("unf_adl", 32'(adl), 32'h00);

      // indexed page cross and fixup
      idle(); do_reset();
      rdy = 1'b1; ld_ahl = 1'b1; db = 8'hF0; tick();
      ld_ahl = 1'b0; op = 4'b1001; rg = 8'h20; ci = 1'b0; #1;
      chk("page_adl", 32'(adl), 32'h10);
      chk("page_co",  32'(co),  32'h1);
      chk("page_fix_pre", 32'(fix), 32'h0);
      tick();
      op = 4'b0000; rg = 8'h10; rdy = 1'b0; #1;
      chk("page_abl", 32'(abl), 32'h10);
      chk("page_fix", 32'(fix), 32'(fix_en));
      tick();
      chk("page_fix_hold", 32'(fix), 32'(fix_en));
      rdy = 1'b1; tick();
      chk("page_fix_done", 32'(fix), 32'h0);

      // PC wrap and rdy gating
      idle(); do_reset();
      rdy = 1'b1; rg = 8'h41; tick();
      ld_pc = 1'b1; rg = 8'hFF; tick();
      chk("pc_load", 32'(pcl), 32'h41);
      rdy = 1'b0; inc_pc = 1'b1; #1;
      chk("pc_wrap_co", 32'(pcl_co), 32'h1);
      tick();
      chk("pc_rdy0", 32'(pcl), 32'h41);
      rdy = 1'b1; tick();
      chk("pc_wrap", 32'(pcl), 32'h00);

      // branch and reset priority
      idle();
      rdy = 1'b1; rg = 8'h80; ld_ahl = 1'b1; db = 8'h77; tick();
      ld_ahl = 1'b0; cond = 1'b1; op = 4'b1111; db = 8'h05; ci = 1'b0; #1;
      chk("branch_adl", 32'(adl), 32'h85);
      ld_pc = 1'b1; tick();
      chk("pre_rst_pcl", 32'(pcl), 32'h80);
      chk("pre_rst_empty", 32'(empty), 32'h0);
      rst_n = 1'b0; ld_ahl = 1'b1; ld_pc = 1'b1; tick();
      rst_n = 1'b1; idle();
      chk("prio_abl",   32'(abl),   32'h0);
      chk("prio_pcl",   32'(pcl),   32'h0);
      chk("prio_empty", 32'(empty), 32'h1);
      chk("prio_fix",   32'(fix),   32'h0);

      // randomized against the reference model
      chk_model = 1'b1;
      for (int n = 0; n < 400; n++) begin
         rst_n  = ($urandom_range(0, 39) != 0);
         rdy    = ($urandom_range(0, 4) != 0);
         ci     = 1'($urandom);
         cond   = 1'($urandom);
         op     = 4'($urandom);
         db     = 8'($urandom);
         rg     = 8'($urandom);
         ld_ahl = 1'($urandom);
         rd_ahl = 1'($urandom);
         ld_pc  = 1'($urandom);
         inc_pc = 1'($urandom);
         tick();
      end
      chk_model = 1'b0;
      rst_n = 1'b1;
      idle();

      // wide instance, depth 1
      do_reset();
      w_rdy = 1'b1; w_ld_ahl = 1'b1; w_db = 16'h1234; tick();
      w_db = 16'h5678; tick();
      w_ld_ahl = 1'b0; w_op = 4'b1010; #1;
      chk("w_full", 32'(w_full), 32'h1);
      chk("w_head", 32'(w_adl),  32'h1234);
      w_ld_ahl = 1'b1; w_rd_ahl = 1'b1; w_db = 16'hABCD; #1;
      chk("w_head_same", 32'(w_adl), 32'h1234);
      tick();
      w_ld_ahl = 1'b0; w_rd_ahl = 1'b0; #1;
      chk("w_replace", 32'(w_adl),  32'hABCD);
      chk("w_full2",   32'(w_full), 32'h1);
      w_rd_ahl = 1'b1; tick();
      w_rd_ahl = 1'b0; #1;
      chk("w_empty", 32'(w_empty), 32'h1);
      chk("w_head0", 32'(w_adl),   32'h0000);
      w_op = 4'b0001; w_rg = 16'hFFFF; w_ci = 1'b1; #1;
      chk("w_carry_adl", 32'(w_adl), 32'h0000);
      chk("w_carry_co",  32'(w_co),  32'h1);
      w_op = 4'b0000; w_ci = 1'b0; w_rg = 16'h1234; tick();
      w_rg = 16'hFFFF; w_ld_pc = 1'b1; tick();
      chk("w_pc_load", 32'(w_pcl), 32'h1234);
      w_inc_pc = 1'b1; #1;
      chk("w_pc_co", 32'(w_pcl_co), 32'h1);
      tick();
      chk("w_pc_wrap", 32'(w_pcl), 32'h0000);
      chk("w_fix", 32'(w_fix), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
